// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX stage that decodes RV32I into ALU function/operands with forwarding and a one-entry output register
module alu_issue_stage #(
    parameter int DataWidth    = 32,
    parameter int RegAddrWidth = 5
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [6:0]              in_opcode_i,
    input  logic [2:0]              in_funct3_i,
    input  logic                    in_funct7b5_i,
    input  logic [RegAddrWidth-1:0] in_rs1_addr_i,
    input  logic [RegAddrWidth-1:0] in_rs2_addr_i,
    input  logic [RegAddrWidth-1:0] in_rd_addr_i,
    input  logic [DataWidth-1:0]    in_rs1_data_i,
    input  logic [DataWidth-1:0]    in_rs2_data_i,
    input  logic [DataWidth-1:0]    in_imm_i,
    input  logic [DataWidth-1:0]    in_pc_i,
    input  logic                    flush_i,
    input  logic                    fwd_mem_wen_i,
    input  logic [RegAddrWidth-1:0] fwd_mem_rd_i,
    input  logic [DataWidth-1:0]    fwd_mem_data_i,
    input  logic                    fwd_wb_wen_i,
    input  logic [RegAddrWidth-1:0] fwd_wb_rd_i,
    input  logic [DataWidth-1:0]    fwd_wb_data_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [3:0]              alu_func_o,
    output logic [DataWidth-1:0]    alu_op1_o,
    output logic [DataWidth-1:0]    alu_op2_o,
    output logic [RegAddrWidth-1:0] out_rd_o,
    output logic [DataWidth-1:0]    out_store_data_o,
    output logic [DataWidth-1:0]    out_pc_o,
    output logic                    out_illegal_o
);
    localparam logic [3:0] ZERO = 4'd0, ADD = 4'd1, SUB = 4'd2, SLL = 4'd3, SLT = 4'd4, XOR = 4'd5,
                           OR = 4'd6, AND = 4'd7, SRL = 4'd8, SRA = 4'd9, SLTU = 4'd10;
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LUI = 7'b0110111,
                           OP_AUIPC = 7'b0010111, OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011,
                           OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;

    function automatic logic [3:0] f3_func(input logic [2:0] f3, input logic sub, input logic sra);
        case (f3)
            3'b000:  return sub ? SUB : ADD;
            3'b001:  return SLL;
            3'b010:  return SLT;
            3'b011:  return SLTU;
            3'b100:  return XOR;
            3'b101:  return sra ? SRA : SRL;
            3'b110:  return OR;
            default: return AND;
        endcase
    endfunction

    logic                    valid_q, ill_q, ill_d, capture;
    logic [3:0]              func_q, func_d;
    logic [DataWidth-1:0]    op1_q, op1_d, op2_q, op2_d, sd_q, pc_q, rs1, rs2;
    logic [RegAddrWidth-1:0] rd_q, rd_d;

    assign in_ready_o = !valid_q || out_ready_i;
    assign capture    = in_valid_i && in_ready_o;

    // MEM result is younger than WB, so it wins; x0 always reads as the register file gives it
    assign rs1 = (fwd_mem_wen_i && fwd_mem_rd_i == in_rs1_addr_i && in_rs1_addr_i != '0) ? fwd_mem_data_i :
                 (fwd_wb_wen_i  && fwd_wb_rd_i  == in_rs1_addr_i && in_rs1_addr_i != '0) ? fwd_wb_data_i  :
                 in_rs1_data_i;
    assign rs2 = (fwd_mem_wen_i && fwd_mem_rd_i == in_rs2_addr_i && in_rs2_addr_i != '0) ? fwd_mem_data_i :
                 (fwd_wb_wen_i  && fwd_wb_rd_i  == in_rs2_addr_i && in_rs2_addr_i != '0) ? fwd_wb_data_i  :
                 in_rs2_data_i;

    always_comb begin
        func_d = ZERO;
        op1_d  = '0;
        op2_d  = '0;
        ill_d  = 1'b0;
        rd_d   = in_rd_addr_i;
        case (in_opcode_i)
            OP_R: begin
                func_d = f3_func(in_funct3_i, in_funct7b5_i, in_funct7b5_i);
                op1_d  = rs1;
                op2_d  = rs2;
            end
            OP_I: begin
                func_d = f3_func(in_funct3_i, 1'b0, in_funct7b5_i);
                op1_d  = rs1;
                op2_d  = in_imm_i;
            end
            OP_LUI: begin
                func_d = ADD;
                op2_d  = in_imm_i;
            end
            OP_AUIPC: begin
                func_d = ADD;
                op1_d  = in_pc_i;
                op2_d  = in_imm_i;
            end
            OP_LOAD, OP_STORE: begin
                func_d = ADD;
                op1_d  = rs1;
                op2_d  = in_imm_i;
                rd_d   = in_opcode_i == OP_STORE ? '0 : in_rd_addr_i;
            end
            OP_BRANCH: begin
                func_d = in_funct3_i[2:1] == 2'b00 ? SUB : in_funct3_i[2:1] == 2'b10 ? SLT :
                         in_funct3_i[2:1] == 2'b11 ? SLTU : ZERO;
                ill_d  = in_funct3_i[2:1] == 2'b01;
                op1_d  = rs1;
                op2_d  = rs2;
                rd_d   = '0;
            end
            OP_JAL, OP_JALR: begin
                func_d = ADD;
                op1_d  = in_pc_i;
                op2_d  = DataWidth'(4);
            end
            default: ill_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            func_q  <= ZERO;
            op1_q   <= '0;
            op2_q   <= '0;
            rd_q    <= '0;
            sd_q    <= '0;
            pc_q    <= '0;
            ill_q   <= 1'b0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (capture) begin
            valid_q <= 1'b1;
            func_q  <= func_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            rd_q    <= rd_d;
            sd_q    <= rs2;
            pc_q    <= in_pc_i;
            ill_q   <= ill_d;
        end else if (out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid_o      = valid_q;
    assign alu_func_o       = func_q;
    assign alu_op1_o        = op1_q;
    assign alu_op2_o        = op2_q;
    assign out_rd_o         = rd_q;
    assign out_store_data_o = sd_q;
    assign out_pc_o         = pc_q;
    assign out_illegal_o    = ill_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: randomized scoreboard bench with an instruction-level reference model
module tb_alu_issue_stage;
    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [4:0]  rs1a, rs2a, rd, mrd, wrd;
        logic [31:0] rs1d, rs2d, imm, pc, md, wd;
        logic        mw, ww, v, rdy, fl;
    } stim_t;

    typedef struct {
        logic [3:0]  func;
        logic [31:0] op1, op2, sd, pc;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    localparam logic [3:0] RTAB [8] = '{4'd1, 4'd3, 4'd4, 4'd10, 4'd5, 4'd8, 4'd6, 4'd7};
    localparam logic [3:0] BTAB [8] = '{4'd2, 4'd2, 4'd0, 4'd0, 4'd4, 4'd4, 4'd10, 4'd10};
    localparam logic [6:0] OPS  [9] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67};

    logic        clk_i = 0, rst_ni = 0;
    logic        in_valid_i = 0, in_funct7b5_i = 0, flush_i = 0, out_ready_i = 1;
    logic        fwd_mem_wen_i = 0, fwd_wb_wen_i = 0;
    logic [6:0]  in_opcode_i = 0;
    logic [2:0]  in_funct3_i = 0;
    logic [4:0]  in_rs1_addr_i = 0, in_rs2_addr_i = 0, in_rd_addr_i = 0, fwd_mem_rd_i = 0, fwd_wb_rd_i = 0;
    logic [31:0] in_rs1_data_i = 0, in_rs2_data_i = 0, in_imm_i = 0, in_pc_i = 0;
    logic [31:0] fwd_mem_data_i = 0, fwd_wb_data_i = 0;
    logic        in_ready_o, out_valid_o, out_illegal_o;
    logic [3:0]  alu_func_o;
    logic [31:0] alu_op1_o, alu_op2_o, out_store_data_o, out_pc_o;
    logic [4:0]  out_rd_o;

    alu_issue_stage dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_opcode_i(in_opcode_i), .in_funct3_i(in_funct3_i), .in_funct7b5_i(in_funct7b5_i),
        .in_rs1_addr_i(in_rs1_addr_i), .in_rs2_addr_i(in_rs2_addr_i), .in_rd_addr_i(in_rd_addr_i),
        .in_rs1_data_i(in_rs1_data_i), .in_rs2_data_i(in_rs2_data_i), .in_imm_i(in_imm_i),
        .in_pc_i(in_pc_i), .flush_i(flush_i), .fwd_mem_wen_i(fwd_mem_wen_i),
        .fwd_mem_rd_i(fwd_mem_rd_i), .fwd_mem_data_i(fwd_mem_data_i), .fwd_wb_wen_i(fwd_wb_wen_i),
        .fwd_wb_rd_i(fwd_wb_rd_i), .fwd_wb_data_i(fwd_wb_data_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .alu_func_o(alu_func_o), .alu_op1_o(alu_op1_o),
        .alu_op2_o(alu_op2_o), .out_rd_o(out_rd_o), .out_store_data_o(out_store_data_o),
        .out_pc_o(out_pc_o), .out_illegal_o(out_illegal_o)
    );

    always #5 clk_i = ~clk_i;

    int   passed = 0, total = 0;
    logic mv = 0, mon_en = 0;
    exp_t sbq[$];
    exp_t last;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) $display("FAIL %s actual=%h required=%h", n, act, req);
        else passed++;
    endtask

    task automatic cmp(input string tag, input exp_t e);
        chk({tag, ".func"}, 32'(alu_func_o), 32'(e.func));
        chk({tag, ".op1"}, alu_op1_o, e.op1);
        chk({tag, ".op2"}, alu_op2_o, e.op2);
        chk({tag, ".rd"}, 32'(out_rd_o), 32'(e.rd));
        chk({tag, ".store_data"}, out_store_data_o, e.sd);
        chk({tag, ".pc"}, out_pc_o, e.pc);
        chk({tag, ".illegal"}, 32'(out_illegal_o), 32'(e.ill));
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] d, input stim_t s);
        if (a == 0) return d;
        if (s.mw && s.mrd == a) return s.md;
        if (s.ww && s.wrd == a) return s.wd;
        return d;
    endfunction

    function automatic exp_t model(input stim_t s);
        exp_t        e;
        logic [31:0] a = fwd(s.rs1a, s.rs1d, s), b = fwd(s.rs2a, s.rs2d, s);
        e.func = 0; e.op1 = 0; e.op2 = 0; e.ill = 0;
        e.sd = b; e.pc = s.pc; e.rd = s.rd;
        if (s.op == 7'h33 || s.op == 7'h13) begin
            e.func = RTAB[s.f3];
            if (s.f3 == 0 && s.f7 && s.op == 7'h33) e.func = 2;
            if (s.f3 == 5 && s.f7) e.func = 9;
            e.op1 = a;
            e.op2 = s.op == 7'h33 ? b : s.imm;
        end else if (s.op == 7'h37) begin
            e.func = 1; e.op2 = s.imm;
        end else if (s.op == 7'h17) begin
            e.func = 1; e.op1 = s.pc; e.op2 = s.imm;
        end else if (s.op == 7'h03 || s.op == 7'h23) begin
            e.func = 1; e.op1 = a; e.op2 = s.imm;
            if (s.op == 7'h23) e.rd = 0;
        end else if (s.op == 7'h63) begin
            e.func = BTAB[s.f3]; e.op1 = a; e.op2 = b; e.rd = 0;
            e.ill = (s.f3 == 2 || s.f3 == 3);
        end else if (s.op == 7'h6f || s.op == 7'h67) begin
            e.func = 1; e.op1 = s.pc; e.op2 = 4;
        end else e.ill = 1;
        return e;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.op = 0; s.f3 = 0; s.f7 = 0; s.rs1a = 0; s.rs2a = 0; s.rd = 0; s.mrd = 0; s.wrd = 0;
        s.rs1d = 0; s.rs2d = 0; s.imm = 0; s.pc = 0; s.md = 0; s.wd = 0;
        s.mw = 0; s.ww = 0; s.v = 0; s.rdy = 1; s.fl = 0;
        return s;
    endfunction

    function automatic stim_t rnd();
        stim_t s = idle();
        int    k = $urandom_range(0, 9);
        s.op = k == 9 ? 7'($urandom) : OPS[k];
        s.f3 = 3'($urandom); s.f7 = 1'($urandom);
        s.rs1a = 5'($urandom_range(0, 7)); s.rs2a = 5'($urandom_range(0, 7)); s.rd = 5'($urandom);
        s.mrd = 5'($urandom_range(0, 7)); s.wrd = 5'($urandom_range(0, 7));
        s.rs1d = $urandom; s.rs2d = $urandom; s.imm = $urandom; s.pc = $urandom;
        s.md = $urandom; s.wd = $urandom; s.mw = 1'($urandom); s.ww = 1'($urandom);
        s.v = $urandom_range(0, 3) != 0; s.rdy = $urandom_range(0, 9) < 7; s.fl = $urandom_range(0, 11) == 0;
        return s;
    endfunction

    // One cycle of stimulus; the bench-side occupancy bit mv predicts handshakes
    task automatic drive(input stim_t s);
        logic cap;
        @(posedge clk_i); #1;
        chk("out_valid", 32'(out_valid_o), 32'(mv));
        in_opcode_i = s.op; in_funct3_i = s.f3; in_funct7b5_i = s.f7;
        in_rs1_addr_i = s.rs1a; in_rs2_addr_i = s.rs2a; in_rd_addr_i = s.rd;
        in_rs1_data_i = s.rs1d; in_rs2_data_i = s.rs2d; in_imm_i = s.imm; in_pc_i = s.pc;
        fwd_mem_wen_i = s.mw; fwd_mem_rd_i = s.mrd; fwd_mem_data_i = s.md;
        fwd_wb_wen_i = s.ww; fwd_wb_rd_i = s.wrd; fwd_wb_data_i = s.wd;
        in_valid_i = s.v; out_ready_i = s.rdy; flush_i = s.fl;
        #1;
        chk("in_ready", 32'(in_ready_o), 32'(!mv || s.rdy));
        cap = s.v && (!mv || s.rdy);
        if (cap && !s.fl) sbq.push_back(model(s));
        mv = s.fl ? 1'b0 : cap ? 1'b1 : s.rdy ? 1'b0 : mv;
    endtask

    always @(negedge clk_i) begin
        if (mon_en) begin
            if (out_valid_o) begin
                if (sbq.size() == 0) chk("unexpected_out_valid", 32'(out_valid_o), 32'd0);
                else begin
                    cmp("entry", sbq[0]);
                    if (out_ready_i || flush_i) last = sbq.pop_front();
                end
            end else cmp("idle_hold", last);
        end
    end

    task automatic clear_last();
        last.func = 0; last.op1 = 0; last.op2 = 0; last.sd = 0; last.pc = 0; last.rd = 0; last.ill = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout reached actual=running required=finished");
        $fatal(1);
    end

    initial begin
        stim_t s;
        clear_last();
        #7;
        chk("reset.out_valid", 32'(out_valid_o), 0);
        chk("reset.alu_func", 32'(alu_func_o), 0);
        chk("reset.op1", alu_op1_o, 0);
        chk("reset.illegal", 32'(out_illegal_o), 0);
        @(negedge clk_i);
        rst_ni = 1;
        mon_en = 1;

        s = idle(); s.v = 1; s.op = 7'h33; s.f7 = 1; s.rs1a = 1; s.rs2a = 2; s.rs1d = 10; s.rs2d = 3;
        drive(s);
        drive(idle());
        chk("sub.func", 32'(alu_func_o), 2);
        chk("sub.op1", alu_op1_o, 10);
        chk("sub.op2", alu_op2_o, 3);

        s = idle(); s.v = 1; s.op = 7'h13; s.f3 = 5; s.f7 = 1; s.imm = 4; s.rs1a = 3; s.rs1d = 32'h8000_0000;
        drive(s);
        s.f7 = 0;
        drive(s);
        chk("srai.func", 32'(alu_func_o), 9);
        chk("srai.op2", alu_op2_o, 4);
        drive(idle());
        chk("srli.func", 32'(alu_func_o), 8);

        s = idle(); s.v = 1; s.op = 7'h33; s.rs1a = 5; s.rs1d = 32'h1234;
        s.mw = 1; s.mrd = 5; s.md = 32'hAAAA; s.ww = 1; s.wrd = 5; s.wd = 32'hBBBB;
        drive(s);
        s.mw = 0;
        drive(s);
        chk("fwd_mem.op1", alu_op1_o, 32'hAAAA);
        s.mw = 1; s.mrd = 0; s.rs1a = 0; s.wrd = 0;
        drive(s);
        chk("fwd_wb.op1", alu_op1_o, 32'hBBBB);
        drive(idle());
        chk("fwd_x0.op1", alu_op1_o, 32'h1234);

        s = idle(); s.v = 1; s.op = 7'h37; s.imm = 32'h5000;
        drive(s);
        s.imm = 32'h6000; s.rdy = 0;
        for (int i = 0; i < 3; i++) begin
            drive(s);
            chk("bp.in_ready", 32'(in_ready_o), 0);
            chk("bp.op2", alu_op2_o, 32'h5000);
        end
        s.rdy = 1;
        drive(s);
        chk("bp_release.in_ready", 32'(in_ready_o), 1);
        drive(idle());
        chk("bp_new.op2", alu_op2_o, 32'h6000);

        s = idle(); s.v = 1; s.op = 7'h17; s.pc = 32'h100; s.imm = 32'h1000; s.fl = 1;
        drive(s);
        s.fl = 0;
        drive(s);
        chk("flush.out_valid", 32'(out_valid_o), 0);
        drive(idle());
        chk("auipc.func", 32'(alu_func_o), 1);
        chk("auipc.op1", alu_op1_o, 32'h100);
        chk("auipc.op2", alu_op2_o, 32'h1000);

        for (int i = 0; i < 3000; i++) drive(rnd());
        for (int i = 0; i < 3; i++) drive(idle());
        chk("queue_drained", 32'(sbq.size()), 0);

        s = idle(); s.v = 1; s.op = 7'h6f; s.pc = 32'h40;
        drive(s);
        drive(idle());
        mon_en = 0;
        chk("prereset.out_valid", 32'(out_valid_o), 1);
        #1 rst_ni = 0;
        #1;
        chk("async_reset.out_valid", 32'(out_valid_o), 0);
        chk("async_reset.alu_func", 32'(alu_func_o), 0);
        chk("async_reset.op1", alu_op1_o, 0);
        sbq.delete();
        clear_last();
        mv = 0;
        @(negedge clk_i);
        rst_ni = 1;
        mon_en = 1;

        s = idle(); s.v = 1; s.op = 7'h7f; s.rs1a = 1; s.rs1d = 7;
        drive(s);
        drive(idle());
        chk("illegal.func", 32'(alu_func_o), 0);
        chk("illegal.flag", 32'(out_illegal_o), 1);
        chk("illegal.op1", alu_op1_o, 0);
        drive(idle());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
ID/EX pipeline stage that sits directly upstream of the ALU. It accepts one decoded RV32I instruction per handshake and translates opcode/funct3/funct7 into the 4-bit ALU function code. It selects and forwards the two ALU operands, then registers func/op1/op2 plus sideband fields for the execute stage. It uses valid/ready flow control with a one-entry output register, a synchronous flush, and 1-cycle latency.

Parameters:
DataWidth, 32, operand/data width
RegAddrWidth, 5, register index width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
in_valid  input  1  upstream instruction valid
in_ready  output  1  stage can accept this cycle
in_opcode  input  7  instr[6:0]
in_funct3  input  3  instr[14:12]
in_funct7b5  input  1  instr[30]
in_rs1_addr  input  5  source register 1 index
in_rs2_addr  input  5  source register 2 index
in_rd_addr  input  5  destination register index
in_rs1_data  input  DataWidth  register-file read data 1
in_rs2_data  input  DataWidth  register-file read data 2
in_imm  input  DataWidth  sign-extended immediate from decode
in_pc  input  DataWidth  instruction PC
flush  input  1  kill the held/incoming instruction
fwd_mem_wen, fwd_mem_rd[5], fwd_mem_data[DataWidth]  input  EX/MEM forward source
fwd_wb_wen, fwd_wb_rd[5], fwd_wb_data[DataWidth]  input  MEM/WB forward source
out_valid  output  1  registered instruction valid
out_ready  input  1  execute stage accepts
alu_func  output  4  ALU function code
alu_op1  output  DataWidth  ALU operand 1
alu_op2  output  DataWidth  ALU operand 2
out_rd  output  5  destination index
out_store_data  output  DataWidth  forwarded rs2 value (stores)
out_pc  output  DataWidth  registered PC
out_illegal  output  1  unrecognised opcode

Behaviour:
- Function codes: ZERO=0, ADD=1, SUB=2, SLL=3, SLT=4, XOR=5, OR=6, AND=7, SRL=8, SRA=9, SLTU=10.
- Reset (rst=0, asynchronous): out_valid=0, alu_func=0, all data outputs=0, out_illegal=0.
- in_ready = !out_valid || out_ready (combinational). Capture occurs on in_valid && in_ready. Outputs appear the next cycle, so latency is 1.
- Hold: while out_valid && !out_ready, every output stays bit-stable.
- Pop without new input: out_valid drops to 0 next cycle. Data outputs keep their last values.
- flush=1 (synchronous) has priority over capture: next cycle out_valid=0. An input handshaken in the same cycle is consumed and discarded.
- Forwarding, evaluated at capture only, for rs1 and rs2 independently:
  - Source is the MEM forward path if fwd_mem_wen && fwd_mem_rd==rsN && rsN!=0.
  - Otherwise the WB forward path if the same conditions hold for fwd_wb_*.
  - Otherwise in_rsN_data.
  - MEM beats WB. Index 0 is never forwarded.
  - Held entries are not re-forwarded; stalling for load-use is the hazard unit's job.
- funct3 map (R-type 0110011 and I-type 0010011):
  - 000: ADD; SUB only for R-type with funct7b5=1.
  - 001: SLL.
  - 010: SLT.
  - 011: SLTU.
  - 100: XOR.
  - 101: SRL, or SRA when funct7b5=1 (applies to I-type as well).
  - 110: OR.
  - 111: AND.
- Operands for R-type: op1=rs1, op2=rs2. Operands for I-type: op1=rs1, op2=imm.
- LUI 0110111: ADD, op1=0, op2=imm.
- AUIPC 0010111: ADD, op1=pc, op2=imm.
- LOAD 0000011 and STORE 0100011: ADD, op1=rs1, op2=imm.
- BRANCH 1100011: op1=rs1, op2=rs2. Function is SUB for f3 000/001, SLT for 100/101, SLTU for 110/111, ZERO with out_illegal=1 for 010/011.
- JAL 1101111 and JALR 1100111: ADD, op1=pc, op2=4 (link value).
- Any other opcode: func=ZERO, op1=op2=0, out_illegal=1.
- out_store_data is always the forwarded rs2 value.
- out_rd is in_rd_addr, or 0 for BRANCH/STORE.
- Arithmetic: none in this stage beyond muxing; widths are DataWidth throughout.

Test Plan:
1. R-type SUB (opcode 0110011, f3=000, f7b5=1), rs1_data=10, rs2_data=3 -> next cycle out_valid=1, alu_func=2, op1=10, op2=3.
2. SRAI (0010011, f3=101, f7b5=1, imm=4), rs1_data=0x80000000 -> alu_func=9, op2=4. Repeat with f7b5=0 -> alu_func=8.
3. Forwarding: rs1=x5, MEM rd=5/0xAAAA, WB rd=5/0xBBBB, both wen -> op1=0xAAAA. Repeat with MEM wen=0 -> op1=0xBBBB. Repeat with rs1=x0 and MEM rd=0 -> op1=in_rs1_data.
4. Backpressure: out_ready=0 for 3 cycles with new in_valid -> in_ready=0 and outputs stable. Then out_ready=1 -> in_ready=1 and the new instruction appears next cycle.
5. flush concurrent with in_valid=1 (AUIPC, pc=0x100, imm=0x1000) -> out_valid=0 next cycle. Without flush -> func=1, op1=0x100, op2=0x1000.
6. Reset mid-operation: drive rst low asynchronously while out_valid=1 -> out_valid=0 and alu_func=0 before the next edge. Opcode 0x7F -> alu_func=0, out_illegal=1.
